load_writeback_mips32: RTL and testbench
========================================

Name: load_writeback_mips32

Overview:
- Write-side driver for the 32-entry MIPS32 register file.
- Queues issued loads in order, pairs each with its returning memory word, then byte-aligns and sign/zero-extends the word (LB/LBU/LH/LHU/LW/LWL/LWR).
- Drives the register file's Rd_addr / Rd_in / active-low Rd_Byte_w_en write port; also merges ALU writebacks and provides a pending-load hazard query for the decode stage.

Parameters:
DATA_WIDTH, 32, register/data width (only 32 supported)
ADDR_WIDTH, 5, register index width
DEPTH, 2, pending-load queue entries (power of two, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
issue_valid  in  1  load issued this cycle
issue_ready  out  1  queue can accept (= not full)
issue_op  in  3  000 LB, 001 LH, 010 LWL, 011 LW, 100 LBU, 101 LHU, 110 LWR, 111 reserved
issue_rd  in  ADDR_WIDTH  destination register
issue_addr_lo  in  2  effective address bits [1:0]
mem_rvalid  in  1  load data returned (in issue order, one per load)
mem_rdata  in  DATA_WIDTH  returned aligned memory word (little-endian)
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU write accepted this cycle
alu_rd  in  ADDR_WIDTH  ALU destination
alu_result  in  DATA_WIDTH  ALU value
query_addr  in  ADDR_WIDTH  decode-stage source register
query_busy  out  1  query_addr is pending in queue
Rd_addr  out  ADDR_WIDTH  register file write address
Rd_in  out  DATA_WIDTH  register file write data
Rd_Byte_w_en  out  4  per-byte write enable, active-low (0 = write byte)
err  out  1  sticky protocol error

Behaviour:
- Reset: queue empty, Rd_addr=0, Rd_in=0, Rd_Byte_w_en=4'b1111, err=0, issue_ready=1.
- Idle write port: Rd_addr=0, Rd_Byte_w_en=4'b1111, Rd_in=0.
- Write port outputs are registered.
  - The register file samples them on the following falling edge.
  - Latency: mem_rvalid at edge N -> write presented after edge N, committed at the falling edge of cycle N.
  - Each write is held exactly one cycle.
- Queue:
  - FIFO of {op, rd, addr_lo}.
  - Push when issue_valid && issue_ready; pop on mem_rvalid.
  - Push and pop in the same cycle are both honoured; count unchanged.
  - issue_ready = (count != DEPTH); no same-cycle bypass when full.
- mem_rvalid with empty queue: data ignored, no write, err set.
- Alignment (a = addr_lo, m = mem_rdata):
  - LB: byte m[8a+7:8a] sign-extended; enables 0000.
  - LBU: same byte, zero-extended; enables 0000.
  - LH: halfword at a[1] (a[0] ignored), sign-extended; enables 0000.
  - LHU: same halfword, zero-extended; enables 0000.
  - LW: m, a ignored; enables 0000.
  - LWL: m[8a+7:0] placed in Rd_in[31:24-8a]. Only bytes 3 down to 3-a are enabled. Remaining Rd_in bits are 0.
  - LWR: m[31:8a] placed in Rd_in[31-8a:0]. Only bytes 3-a down to 0 are enabled. Remaining Rd_in bits are 0.
  - Op 111: entry retired, no write, err set.
- rd=0: entry retired normally; Rd_addr driven 0, so the write is a no-op.
- Arbitration: a load return has priority.
  - alu_ready = !mem_rvalid.
  - The ALU write (all enables 0) is registered when alu_valid && alu_ready.
  - The ALU source holds its request while alu_ready=0.
- query_busy = 1 when query_addr != 0 and any valid entry has rd == query_addr.
  - Combinational; an entry popping this cycle still counts.
- Reset mid-operation: all pending entries discarded. A write already presented completes its falling edge only if rst was not sampled at the preceding rising edge.

Optional Feature:
- Macro: LWLR_EN.
- Defined: LWL/LWR behave as above.
- Undefined:
  - Ops 010 and 110 are treated as reserved: no write, err set.
  - The alignment mux is reduced to byte/half/word only.

Test Plan:
1. Issue LB rd=5 a=2, then return m=32'h1280_3456 -> Rd_addr=5, Rd_in=32'hFFFF_FF80, enables 4'b0000, for one cycle.
2. Issue LHU rd=7 a=2 and LH rd=8 a=0 back-to-back; return 32'h8001_F00F then 32'h0000_9ABC -> writes r7=32'h0000_8001, then r8=32'hFFFF_9ABC, in order. issue_ready=0 after the second push (DEPTH=2).
3. LWLR_EN defined, LWL rd=3 a=1, m=32'hAABB_CCDD -> Rd_in=32'hCCDD_0000, enables 4'b0011. Then LWR rd=3 a=1 -> Rd_in=32'h00AA_BBCC, enables 4'b1000.
4. mem_rvalid and alu_valid (rd=9, 32'h1234) in the same cycle -> load write first, alu_ready=0. The ALU write follows next cycle with Rd_addr=9.
5. Pending LW rd=4 -> query_busy=1 for query_addr=4, 0 for query_addr=0 and 6. After return, query_busy=0.
6. mem_rvalid with empty queue -> no write, err=1 and sticky. Assert rst mid-queue with 2 entries -> issue_ready=1, query_busy=0, err=0 next cycle.

Source files
------------

// File: rtl/load_writeback_mips32.sv
// Load writeback for the MIPS32 register file: in-order load queue, byte alignment/extension,
// ALU write merge and pending-load hazard query. Define LWLR_EN to support LWL/LWR.
module load_writeback_mips32 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [2:0]            issue_op,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [1:0]            issue_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [ADDR_WIDTH-1:0] query_addr,
  output logic                  query_busy,
  output logic [ADDR_WIDTH-1:0] Rd_addr,
  output logic [DATA_WIDTH-1:0] Rd_in,
  output logic [3:0]            Rd_Byte_w_en,
  output logic                  err
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [2:0]            op;
    logic [ADDR_WIDTH-1:0] rd;
    logic [1:0]            lo;
  } entry_t;

  entry_t                mem_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] rd_in_q, rd_in_d;
  logic [3:0]            en_q, en_d;
  logic                  err_q, err_d;

  logic                  full, empty, push, pop;
  entry_t                head;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;

  assign full        = &valid_q;
  assign empty       = ~|valid_q;
  assign issue_ready = ~full;
  assign alu_ready   = ~mem_rvalid;
  assign push        = issue_valid && issue_ready;
  assign pop         = mem_rvalid && !empty;

  assign head   = mem_q[rd_ptr_q];
  assign byte_v = mem_rdata[{head.lo, 3'b000} +: 8];
  assign half_v = head.lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    rd_addr_d = '0;
    rd_in_d   = '0;
    en_d      = 4'b1111;
    err_d     = err_q;
    if (mem_rvalid) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        rd_addr_d = head.rd;
        en_d      = 4'b0000;
        unique case (head.op)
          3'b000: rd_in_d = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
          3'b100: rd_in_d = {{(DATA_WIDTH-8){1'b0}}, byte_v};
          3'b001: rd_in_d = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
          3'b101: rd_in_d = {{(DATA_WIDTH-16){1'b0}}, half_v};
          3'b011: rd_in_d = mem_rdata;
`ifdef LWLR_EN
          // LWL fills from the top byte down; LWR fills from the bottom byte up.
          3'b010: begin
            rd_in_d = mem_rdata << {~head.lo, 3'b000};
            en_d    = 4'b0111 >> head.lo;
          end
          3'b110: begin
            rd_in_d = mem_rdata >> {head.lo, 3'b000};
            en_d    = 4'b1110 << ~head.lo;
          end
`endif
          default: begin
            rd_addr_d = '0;
            en_d      = 4'b1111;
            err_d     = 1'b1;
          end
        endcase
      end
    end else if (alu_valid) begin
      rd_addr_d = alu_rd;
      rd_in_d   = alu_result;
      en_d      = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_addr_q <= '0;
      rd_in_q   <= '0;
      en_q      <= 4'b1111;
      err_q     <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q]   <= '{op: issue_op, rd: issue_rd, lo: issue_addr_lo};
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      rd_addr_q <= rd_addr_d;
      rd_in_q   <= rd_in_d;
      en_q      <= en_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    query_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && mem_q[i].rd == query_addr) query_busy = 1'b1;
    end
    if (query_addr == '0) query_busy = 1'b0;
  end

  assign Rd_addr      = rd_addr_q;
  assign Rd_in        = rd_in_q;
  assign Rd_Byte_w_en = en_q;
  assign err          = err_q;

endmodule

// File: tb/tb_load_writeback_mips32.sv
// Scoreboard bench for load_writeback_mips32; LWL/LWR vectors apply when LWLR_EN is defined.
module tb_load_writeback_mips32;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_op;
  logic [4:0]  issue_rd;
  logic [1:0]  issue_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic [4:0]  query_addr;
  logic        query_busy;
  logic [4:0]  Rd_addr;
  logic [31:0] Rd_in;
  logic [3:0]  Rd_Byte_w_en;
  logic        err;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  en;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  load_writeback_mips32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_op     (issue_op),
    .issue_rd     (issue_rd),
    .issue_addr_lo(issue_addr_lo),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_result   (alu_result),
    .query_addr   (query_addr),
    .query_busy   (query_busy),
    .Rd_addr      (Rd_addr),
    .Rd_in        (Rd_in),
    .Rd_Byte_w_en (Rd_Byte_w_en),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (Rd_Byte_w_en !== 4'b1111) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data %h en %b expected none",
                 Rd_addr, Rd_in, Rd_Byte_w_en);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (Rd_addr !== e.addr || Rd_in !== e.data || Rd_Byte_w_en !== e.en) begin
          n_bad++;
          $display("FAIL write: got addr %0d data %h en %b expected addr %0d data %h en %b",
                   Rd_addr, Rd_in, Rd_Byte_w_en, e.addr, e.data, e.en);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] en);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.en   = en;
    exp_q.push_back(w);
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [1:0] lo);
    issue_valid   = 1'b1;
    issue_op      = op;
    issue_rd      = rd;
    issue_addr_lo = lo;
    cycle();
    issue_valid   = 1'b0;
  endtask

  task automatic ret(input logic [31:0] m);
    mem_rvalid = 1'b1;
    mem_rdata  = m;
    cycle();
    mem_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_op = '0; issue_rd = '0; issue_addr_lo = '0;
    mem_rvalid = 1'b0; mem_rdata = '0; alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
    query_addr = '0;
    cycle();
    cycle();
    rst = 1'b0;
    check("reset_rd_addr", 32'(Rd_addr), 32'd0);
    check("reset_rd_in", Rd_in, 32'd0);
    check("reset_en", 32'(Rd_Byte_w_en), 32'hF);
    check("reset_err", 32'(err), 32'd0);
    check("reset_issue_ready", 32'(issue_ready), 32'd1);

    // LB sign extension
    issue(3'b000, 5'd5, 2'd2);
    expect_wr(5'd5, 32'hFFFF_FF80, 4'b0000);
    ret(32'h1280_3456);
    cycle();

    // LHU then LH back-to-back, queue fills
    issue(3'b101, 5'd7, 2'd2);
    issue(3'b001, 5'd8, 2'd0);
    check("full_issue_ready", 32'(issue_ready), 32'd0);
    expect_wr(5'd7, 32'h0000_8001, 4'b0000);
    expect_wr(5'd8, 32'hFFFF_9ABC, 4'b0000);
    ret(32'h8001_F00F);
    ret(32'h0000_9ABC);
    check("drained_issue_ready", 32'(issue_ready), 32'd1);

    // More alignment cases: LBU a=3, LH a=3 (a[0] ignored), LW, rd=0
    issue(3'b100, 5'd1, 2'd3);
    expect_wr(5'd1, 32'h0000_0092, 4'b0000);
    ret(32'h9212_3456);
    issue(3'b001, 5'd2, 2'd3);
    expect_wr(5'd2, 32'h0000_7FEE, 4'b0000);
    ret(32'h7FEE_8000);
    issue(3'b011, 5'd0, 2'd1);
    expect_wr(5'd0, 32'h0000_0055, 4'b0000);
    ret(32'h0000_0055);
    cycle();

    // LWL / LWR
    issue(3'b010, 5'd3, 2'd1);
    issue(3'b110, 5'd3, 2'd1);
`ifdef LWLR_EN
    expect_wr(5'd3, 32'hCCDD_0000, 4'b0011);
    expect_wr(5'd3, 32'h00AA_BBCC, 4'b1000);
    ret(32'hAABB_CCDD);
    ret(32'hAABB_CCDD);
    check("lwlr_err", 32'(err), 32'd0);
`else
    ret(32'hAABB_CCDD);
    ret(32'hAABB_CCDD);
    check("lwlr_reserved_err", 32'(err), 32'd1);
    do_reset();
`endif
    cycle();

    // Reserved op 111
    issue(3'b111, 5'd6, 2'd0);
    ret(32'h1111_1111);
    check("op111_err", 32'(err), 32'd1);
    do_reset();

    // Load return and ALU request collide
    issue(3'b011, 5'd10, 2'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_result = 32'h0000_1234;
    #1;
    check("alu_ready_blocked", 32'(alu_ready), 32'd0);
    expect_wr(5'd10, 32'hCAFE_F00D, 4'b0000);
    expect_wr(5'd9, 32'h0000_1234, 4'b0000);
    cycle();
    mem_rvalid = 1'b0;
    #1;
    check("alu_ready_free", 32'(alu_ready), 32'd1);
    cycle();
    alu_valid = 1'b0;
    cycle();

    // Hazard query
    issue(3'b011, 5'd4, 2'd0);
    query_addr = 5'd4; #1;
    check("query_r4", 32'(query_busy), 32'd1);
    query_addr = 5'd0; #1;
    check("query_r0", 32'(query_busy), 32'd0);
    query_addr = 5'd6; #1;
    check("query_r6", 32'(query_busy), 32'd0);
    query_addr = 5'd4;
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_BEEF; #1;
    check("query_popping", 32'(query_busy), 32'd1);
    expect_wr(5'd4, 32'h0BAD_BEEF, 4'b0000);
    cycle();
    mem_rvalid = 1'b0; #1;
    check("query_after", 32'(query_busy), 32'd0);
    cycle();

    // Empty-queue return and sticky error
    check("err_before", 32'(err), 32'd0);
    ret(32'h5555_5555);
    check("err_empty", 32'(err), 32'd1);
    cycle();
    cycle();
    check("err_sticky", 32'(err), 32'd1);

    // Reset mid-queue
    issue(3'b011, 5'd11, 2'd0);
    issue(3'b011, 5'd12, 2'd0);
    query_addr = 5'd11; #1;
    check("pre_rst_ready", 32'(issue_ready), 32'd0);
    check("pre_rst_busy", 32'(query_busy), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_ready", 32'(issue_ready), 32'd1);
    check("rst_busy", 32'(query_busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_en", 32'(Rd_Byte_w_en), 32'hF);

    repeat (3) cycle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
